// File: rtl/axi_ddr_front.sv
// rtl/axi_ddr_front.sv - AXI4 INCR burst front end serialising bursts into single-beat controller requests
module axi_ddr_front #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BEAT_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [3:0]            awlen,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [3:0]            arlen,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic [ADDR_W-1:0]     logical_addr,
  output logic [DATA_W-1:0]     pwdata,
  output logic                  pwrite,
  output logic                  pvalid,
  input  logic                  pready,
  input  logic [DATA_W-1:0]     prdata,
  output logic [3:0]            burstlen,
  output logic [DATA_W/8-1:0]   strobe
);

  localparam logic [9:0] COL_INC = 10'(BEAT_BYTES);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_ISSUE, WR_RESP, RD_ISSUE, RD_DATA} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q, cnt_q;
  logic              err_q, rr_rd_q;
  logic              idle, grant_w, grant_r, last_beat;
  logic [ADDR_W-1:0] addr_inc;

  // Beats stay inside the 1 KB column window; bank/row bits never move.
  assign addr_inc  = {addr_q[ADDR_W-1:10], addr_q[9:0] + COL_INC};
  assign last_beat = (cnt_q == len_q);

  // rr_rd_q set means the read channel wins the next simultaneous request.
  assign idle    = (state == IDLE);
  assign grant_w = idle && awvalid && (!arvalid || !rr_rd_q);
  assign grant_r = idle && arvalid && (!awvalid || rr_rd_q);
  assign awready = rst && idle && !grant_r;
  assign arready = rst && idle && !grant_w;
  assign wready  = (state == WR_DATA);
  assign rresp   = 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant_w) state_nxt = WR_DATA;
                else if (grant_r) state_nxt = RD_ISSUE;
      WR_DATA:  if (wvalid) state_nxt = WR_ISSUE;
      WR_ISSUE: if (pready) state_nxt = last_beat ? WR_RESP : WR_DATA;
      WR_RESP:  if (bready) state_nxt = IDLE;
      RD_ISSUE: if (pready) state_nxt = RD_DATA;
      RD_DATA:  if (rready) state_nxt = last_beat ? IDLE : RD_ISSUE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      rr_rd_q      <= 1'b0;
      burstlen     <= '0;
      logical_addr <= '0;
      pwdata       <= '0;
      pwrite       <= 1'b0;
      pvalid       <= 1'b0;
      strobe       <= '0;
      bvalid       <= 1'b0;
      bresp        <= 2'b00;
      rvalid       <= 1'b0;
      rdata        <= '0;
      rlast        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_w) begin
            addr_q   <= awaddr;
            len_q    <= awlen;
            burstlen <= awlen;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rr_rd_q  <= 1'b1;
          end else if (grant_r) begin
            addr_q       <= araddr;
            len_q        <= arlen;
            burstlen     <= arlen;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rr_rd_q      <= 1'b0;
            logical_addr <= araddr;
            pwrite       <= 1'b0;
            strobe       <= '1;
            pvalid       <= 1'b1;
          end
        end
        WR_DATA: begin
          if (wvalid) begin
            pwdata       <= wdata;
            strobe       <= wstrb;
            pwrite       <= 1'b1;
            pvalid       <= 1'b1;
            logical_addr <= addr_q;
            if (wlast != last_beat) err_q <= 1'b1;
          end
        end
        WR_ISSUE: begin
          if (pready) begin
            pvalid <= 1'b0;
            if (last_beat) begin
              bvalid <= 1'b1;
              bresp  <= err_q ? 2'b10 : 2'b00;
            end else begin
              cnt_q  <= cnt_q + 4'd1;
              addr_q <= addr_inc;
            end
          end
        end
        WR_RESP: begin
          if (bready) bvalid <= 1'b0;
        end
        RD_ISSUE: begin
          if (pready) begin
            rdata  <= prdata;
            rvalid <= 1'b1;
            rlast  <= last_beat;
            pvalid <= 1'b0;
          end
        end
        RD_DATA: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (!last_beat) begin
              cnt_q        <= cnt_q + 4'd1;
              addr_q       <= addr_inc;
              logical_addr <= addr_inc;
              pvalid       <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ddr_front.sv
// tb/tb_axi_ddr_front.sv - randomized self-checking bench for axi_ddr_front against a burst-level model
module tb_axi_ddr_front;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast, pwrite, pvalid, pready;
  logic [31:0] awaddr, araddr, wdata, rdata, logical_addr, pwdata, prdata;
  logic [3:0]  awlen, arlen, wstrb, burstlen, strobe;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_ddr_front dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .logical_addr(logical_addr), .pwdata(pwdata), .pwrite(pwrite), .pvalid(pvalid),
    .pready(pready), .prdata(prdata), .burstlen(burstlen), .strobe(strobe)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        wr;
    logic [3:0]  blen;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] pd_q[$];
  logic [31:0] wd_q[$];
  byte         grant_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pdly_lo = 0, pdly_hi = 3, rdly_lo = 0, rdly_hi = 3;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Column index is byte address / 4, modulo 256 columns per 1 KB window.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i);
    logic [31:0] col;
    col = ((a >> 2) + 32'(i)) % 256;
    return (a & 32'hFFFF_FC03) | (col << 2);
  endfunction

  // Controller model: random stall, checks each issued beat against the expected stream.
  initial begin
    int wc, dly;
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_strb;
    logic        s_wr;
    beat_t       e;
    pready = 1'b0; prdata = '0; wc = 0; dly = 0;
    forever begin
      @(negedge clk);
      pready = 1'b0;
      if (!pvalid) begin
        wc = 0;
        if ($urandom_range(0, 3) == 0) begin
          pready = 1'b1;
          prdata = $urandom;
        end
      end else begin
        if (wc == 0) begin
          s_addr = logical_addr; s_data = pwdata; s_strb = strobe; s_wr = pwrite;
          dly = $urandom_range(pdly_lo, pdly_hi);
        end else begin
          check_eq("p_hold_addr", logical_addr, s_addr);
          check_eq("p_hold_ctl", {pwdata, strobe, pwrite}, {s_data, s_strb, s_wr});
        end
        if (wc >= dly) begin
          pready = 1'b1;
          prdata = (pd_q.size() > 0) ? pd_q.pop_front() : $urandom;
          check_eq("p_beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("p_addr", logical_addr, e.addr);
            check_eq("p_write", pwrite, e.wr);
            check_eq("p_strobe", strobe, e.strb);
            check_eq("p_burstlen", burstlen, e.blen);
            if (e.wr) check_eq("p_wdata", pwdata, e.data);
            else rd_q.push_back(prdata);
          end
          wc = 0;
        end else begin
          wc++;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst && awvalid && arvalid) check_eq("one_grant", awready && arready, 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic do_write(input logic [31:0] a, input logic [3:0] len, input int wlast_at,
                          input bit full_strb);
    logic [31:0] d[16];
    logic [3:0]  s[16];
    logic        err;
    int          n, k;
    beat_t       e;
    err = (wlast_at != int'(len));
    for (int i = 0; i <= int'(len); i++) begin
      d[i] = (wd_q.size() > 0) ? wd_q.pop_front() : $urandom;
      s[i] = full_strb ? 4'hF : 4'($urandom);
    end
    awvalid = 1'b1; awaddr = a; awlen = len;
    n = 0; #1;
    while (!awready && n < 400) begin @(negedge clk); #1; n++; end
    check_eq("aw_accept", awready, 1);
    grant_log.push_back(8'h57);
    for (int i = 0; i <= int'(len); i++) begin
      e.addr = beat_addr(a, i); e.data = d[i]; e.strb = s[i]; e.wr = 1'b1; e.blen = len;
      exp_q.push_back(e);
    end
    @(negedge clk);
    awvalid = 1'b0; awaddr = $urandom; awlen = 4'($urandom);
    for (int i = 0; i <= int'(len); i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      wvalid = 1'b1; wdata = d[i]; wstrb = s[i]; wlast = (i == wlast_at);
      n = 0; #1;
      while (!wready && n < 400) begin @(negedge clk); #1; n++; end
      check_eq("w_accept", wready, 1);
      @(negedge clk);
      wvalid = 1'b0; wlast = 1'b0;
    end
    bready = 1'($urandom_range(0, 1));
    n = 0; #1;
    while (!bvalid && n < 400) begin @(negedge clk); #1; n++; end
    check_eq("b_valid", bvalid, 1);
    check_eq("bresp", bresp, err ? 2'b10 : 2'b00);
    if (!bready) begin
      k = $urandom_range(0, 3);
      repeat (k) begin @(negedge clk); #1; check_eq("b_hold", bvalid, 1); end
      @(negedge clk);
      bready = 1'b1;
    end
    @(negedge clk);
    bready = 1'b0;
    check_eq("b_drop", bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] len);
    logic [31:0] exp_d;
    int          n, k;
    beat_t       e;
    arvalid = 1'b1; araddr = a; arlen = len;
    n = 0; #1;
    while (!arready && n < 400) begin @(negedge clk); #1; n++; end
    check_eq("ar_accept", arready, 1);
    grant_log.push_back(8'h52);
    for (int i = 0; i <= int'(len); i++) begin
      e.addr = beat_addr(a, i); e.data = '0; e.strb = 4'hF; e.wr = 1'b0; e.blen = len;
      exp_q.push_back(e);
    end
    @(negedge clk);
    arvalid = 1'b0; araddr = $urandom; arlen = 4'($urandom);
    for (int i = 0; i <= int'(len); i++) begin
      n = 0; #1;
      while (!rvalid && n < 400) begin @(negedge clk); #1; n++; end
      check_eq("r_valid", rvalid, 1);
      check_eq("r_source", rd_q.size() > 0, 1);
      exp_d = (rd_q.size() > 0) ? rd_q.pop_front() : '1;
      check_eq("rdata", rdata, exp_d);
      check_eq("rlast", rlast, i == int'(len));
      check_eq("rresp", rresp, 0);
      k = $urandom_range(rdly_lo, rdly_hi);
      repeat (k) begin
        @(negedge clk); #1;
        check_eq("r_hold_valid", rvalid, 1);
        check_eq("r_hold_data", rdata, exp_d);
      end
      @(negedge clk);
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  initial begin
    int n, s;
    logic [3:0] len;
    awvalid = 0; awaddr = 0; awlen = 0; wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
    bready = 0; arvalid = 0; araddr = 0; arlen = 0; rready = 0;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ctl", {awready, arready, wready, bvalid, bresp, rvalid, rlast, pwrite, pvalid,
                         burstlen, strobe}, 0);
    check_eq("rst_data", {logical_addr, pwdata}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("idle_ready", {awready, arready, wready}, 3'b110);
    @(negedge clk);

    // Single write, fixed 3-cycle controller stall.
    pdly_lo = 3; pdly_hi = 3;
    wd_q.push_back(32'hA5A5_0001);
    do_write(32'h0000_03E8, 4'd0, 0, 1'b1);
    check_eq("exp_drain_w1", exp_q.size(), 0);

    // 4-beat read with known controller data.
    pdly_lo = 0; pdly_hi = 3;
    pd_q.push_back(32'd10); pd_q.push_back(32'd20); pd_q.push_back(32'd30); pd_q.push_back(32'd40);
    do_read(32'h0000_07D0, 4'd3);
    check_eq("exp_drain_r4", exp_q.size(), 0);

    // Column wrap across the 1 KB window.
    do_write(32'h0000_03F8, 4'd3, 3, 1'b0);
    check_eq("exp_drain_wrap", exp_q.size(), 0);

    // Backpressure on both the controller and the R channel.
    pdly_lo = 10; pdly_hi = 10; rdly_lo = 5; rdly_hi = 5;
    do_read(32'h1234_5100, 4'd1);
    check_eq("exp_drain_bp", exp_q.size(), 0);
    pdly_lo = 0; pdly_hi = 3; rdly_lo = 0; rdly_hi = 3;

    // Early wlast on the first beat of a 3-beat burst.
    do_write(32'h0000_0100, 4'd2, 0, 1'b0);
    check_eq("exp_drain_err", exp_q.size(), 0);

    // Reset in the middle of a read burst.
    pdly_lo = 2; pdly_hi = 2;
    arvalid = 1'b1; araddr = 32'h0000_2000; arlen = 4'd3;
    n = 0; #1;
    while (!arready && n < 400) begin @(negedge clk); #1; n++; end
    check_eq("rst_ar_accept", arready, 1);
    for (int i = 0; i < 4; i++) exp_q.push_back('{beat_addr(32'h2000, i), 32'h0, 4'hF, 1'b0, 4'd3});
    @(negedge clk);
    arvalid = 1'b0;
    n = 0; #1;
    while (!rvalid && n < 400) begin @(negedge clk); #1; n++; end
    check_eq("rst_mid_rvalid", rvalid, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_mid_ctl", {awready, arready, wready, bvalid, bresp, rvalid, rlast, pwrite, pvalid,
                             burstlen, strobe}, 0);
    check_eq("rst_mid_data", {logical_addr, pwdata}, 0);
    check_eq("rst_mid_rdata", rdata, 0);
    exp_q.delete();
    rd_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_idle_ready", {awready, arready}, 2'b11);
    repeat (4) begin
      @(negedge clk); #1;
      check_eq("no_stale_beat", {rvalid, pvalid, bvalid}, 0);
    end
    @(negedge clk);
    pdly_lo = 0; pdly_hi = 3;

    // Two simultaneous AW/AR requests in a row: write first, then read.
    s = grant_log.size();
    fork
      begin
        do_write(32'h0001_0040, 4'd1, 1, 1'b0);
        do_write(32'h0001_0080, 4'd0, 0, 1'b0);
      end
      do_read(32'h0002_00C0, 4'd2);
    join
    check_eq("arb_first", grant_log[s], 8'h57);
    check_eq("arb_second", grant_log[s+1], 8'h52);
    check_eq("arb_third", grant_log[s+2], 8'h57);
    check_eq("exp_drain_arb", exp_q.size(), 0);

    // Randomized bursts.
    for (int t = 0; t < 30; t++) begin
      len = 4'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_write($urandom, len, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : int'(len), 1'b0);
      else
        do_read($urandom, len);
      check_eq("exp_drain_rand", exp_q.size(), 0);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
